// File: rtl/cam_capture.sv
// cam_capture: oversampled camera byte stream -> RGB565 frame-buffer write strobes.
// Latency: cam_* pass 2 sync flops; frame_we rises one clk25 after the second byte's pclk rise is seen.
// Backpressure: none; one write per strobe; pixels beyond the frame are dropped and set overflow.
// Build option: define CAPTURE_ALT_FRAME_EN to capture only every other enabled frame start.
module cam_capture #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [16:0] frame_addr,
    output logic [15:0] frame_pixel,
    output logic        frame_we,
    output logic        frame_done,
    output logic        overflow
);
    localparam logic [16:0] LAST_ADDR = 17'(H_PIX * V_LINES - 1);

    typedef enum logic [1:0] {WAIT_VSYNC, WAIT_START, CAPTURE, SKIP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [10:0] r_sync1;      // {vsync, href, pclk, data}
    logic [10:0] r_sync2;
    logic [2:0]  r_prev;       // previous synced {vsync, href, pclk}
    logic [16:0] r_addr;
    logic [15:0] r_pixel;
    logic [7:0]  r_hi;
    logic        r_we;
    logic        r_done;
    logic        r_ovf;
    logic        r_phase;
    logic        r_full;       // last frame address has been written
    logic        w_start_cap;
    logic        w_leave_cap;

    logic       w_vs, w_href, w_pclk;
    logic [7:0] w_data;
    logic       w_vs_rise, w_vs_fall, w_href_fall, w_pclk_rise, w_full;

    assign w_vs        = r_sync2[10];
    assign w_href      = r_sync2[9];
    assign w_pclk      = r_sync2[8];
    assign w_data      = r_sync2[7:0];
    assign w_vs_rise   = w_vs & ~r_prev[2];
    assign w_vs_fall   = ~w_vs & r_prev[2];
    assign w_href_fall = ~w_href & r_prev[1];
    assign w_pclk_rise = w_pclk & ~r_prev[0];
    // A write to the last address in flight counts as full so no later pixel can slip past it.
    assign w_full      = r_full | (r_we & (r_addr == LAST_ADDR));

`ifdef CAPTURE_ALT_FRAME_EN
    logic r_alt_skip;      // high when the next enabled frame start must be skipped

    // Toggle on every enabled frame start so captures alternate, starting with a capture.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_alt_skip <= 1'b0;
        end else if (r_state == WAIT_START && w_vs_fall && capture_en) begin
            r_alt_skip <= ~r_alt_skip;
        end
    end
`endif

    // Two-flop synchronizer for all camera inputs, plus one history flop for edge detection.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {cam_vsync, cam_href, cam_pclk, cam_data};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2[10:8];
        end
    end

    // Frame-tracking state register.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_VSYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; frame start and frame end events feed the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_start_cap = 1'b0;
        w_leave_cap = 1'b0;
        case (r_state)
            WAIT_VSYNC: begin
                if (w_vs) w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (w_vs_fall) begin
`ifdef CAPTURE_ALT_FRAME_EN
                    w_start_cap = capture_en & ~r_alt_skip;
`else
                    w_start_cap = capture_en;
`endif
                    w_state_nxt = w_start_cap ? CAPTURE : SKIP;
                end
            end
            CAPTURE: begin
                if (w_vs_rise) begin
                    w_state_nxt = WAIT_START;
                    w_leave_cap = 1'b1;
                end
            end
            SKIP: begin
                if (w_vs_rise) w_state_nxt = WAIT_START;
            end
            default: w_state_nxt = WAIT_VSYNC;
        endcase
    end

    // Byte pairing, write strobe, address advance and overflow tracking.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_pixel <= '0;
            r_hi    <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_phase <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= w_leave_cap;
            if (r_we) begin
                if (r_addr == LAST_ADDR) r_full <= 1'b1;
                else                     r_addr <= r_addr + 17'd1;
            end
            // Completion is still honoured on the vsync-rise cycle so a pending word is not lost.
            if (r_state == CAPTURE) begin
                if (w_href_fall) begin
                    r_phase <= 1'b0;
                end else if (w_pclk_rise && w_href) begin
                    if (!r_phase) begin
                        r_hi    <= w_data;
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_pixel <= {r_hi, w_data};
                        end
                    end
                end
            end
            // A new captured frame starts clean; placed last so it wins over a trailing write.
            if (w_start_cap) begin
                r_addr  <= '0;
                r_phase <= 1'b0;
                r_ovf   <= 1'b0;
                r_full  <= 1'b0;
            end
        end
    end

    assign frame_addr  = r_addr;
    assign frame_pixel = r_pixel;
    assign frame_we    = r_we;
    assign frame_done  = r_done;
    assign overflow    = r_ovf;

endmodule
